uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer sitting directly downstream of the `Uart8` receiver. Captures each byte on the receiver's `rxDone` pulse into a power-of-two circular FIFO and presents it to the consuming logic over a valid/ready interface. Provides level, full/empty, sticky overflow and framing-error accounting.

## Interface
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `AW`, `$clog2(DEPTH)`: pointer index width; derived, not overridden.

Ports:
- `clk`  in  1  system clock (same clock as `Uart8`).
- `reset`  in  1  reset; asynchronous, active-low.
- `rxDone`  in  1  one-cycle pulse from `Uart8`; byte on `rxByte` is valid this cycle.
- `rxErr`  in  1  framing error qualifier, sampled with `rxDone`.
- `rxByte`  in  8  received byte (`Uart8.rxOut`).
- `outData`  out  8  head-of-FIFO byte; forced to 8'h00 while `outValid`=0.
- `outValid`  out  1  FIFO non-empty.
- `outReady`  in  1  consumer accepts head byte when high with `outValid`.
- `outErr`  out  1  error tag of head byte (present only with `UART_RX_FIFO_ERR_TAG_EN`).
- `count`  out  AW+1  current occupancy, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky: a byte was dropped because the FIFO was full.
- `clearOverflow`  in  1  synchronous clear of `overflow`.
- `errCount`  out  8  saturating count of `rxDone` pulses with `rxErr`=1.

## Operation
- Push = `rxDone` (and, without tag feature, `!rxErr`). Pop = `outValid && outReady`.
- Write pointer `wp`, read pointer `rp`, both AW+1 bits; index = low AW bits; MSB distinguishes full from empty on wrap. `count = wp - rp` modulo 2^(AW+1).
- Push while not full: write `mem[wp[AW-1:0]]`, `wp++`.
- Push while full with no pop: byte dropped, pointers unchanged, `overflow` set.
- Push and pop in same cycle while full: both occur, `count` unchanged, no overflow.
- Push and pop in same cycle while empty: impossible (`outValid`=0); push only.
- `overflow`: set wins over `clearOverflow` when both occur in the same cycle.
- `errCount`: increments on each `rxDone && rxErr`, saturates at 255; cleared only by reset.
- Pointer wrap: index rolls DEPTH-1 → 0 with MSB toggling; no data loss across wrap.
- `outData`/`outErr` are combinational reads of `mem[rp]`, gated to 0 when empty.

## Timing
- Reset (async assert, sync release): `wp`=`rp`=0, `count`=0, `empty`=1, `full`=0, `outValid`=0, `outData`=8'h00, `outErr`=0, `overflow`=0, `errCount`=0. Memory contents not reset.
- Push latency: byte written at edge N is on `outData` with `outValid`=1 from edge N onward (visible in the cycle after the `rxDone` cycle).
- Pop: head advances at the edge where `outValid && outReady`; next byte visible immediately after that edge; back-to-back pops at one per cycle.
- `count`, `full`, `empty` registered-consistent with pointers; updated at the same edge as the push/pop.
- `outReady` while `outValid`=0 has no effect.
- Reset asserted mid-stream discards all contents; no partial state survives.

## Configuration
- `UART_RX_FIFO_ERR_TAG_EN` defined: entries are 9 bits {err, byte}; bytes with `rxErr`=1 are stored; `outErr` port exists and reflects head entry.
- Undefined: entries are 8 bits; bytes with `rxErr`=1 are discarded (not pushed, never cause overflow); no `outErr` port. `errCount` behaves identically in both builds.

## Structure
- Shared package `uart_pkg`: `UART_BYTE_W` = 8, `UART_RX_FIFO_DEPTH_DEFAULT` = 16, `UART_ERRCNT_W` = 8, entry-width constant selected by the macro.
- One sub-module: `uart_fifo_mem` — DEPTH×W storage, one synchronous write port, one asynchronous read port; no reset.
- Pointer, flag and counter logic stay in `uart_rx_fifo`.

## Test plan
- Reset then idle: all outputs at reset values; `outReady`=1 for 10 cycles → `count` stays 0, `outValid` stays 0.
- Push 8'h35, 8'hA5, 8'h00 with `outReady`=0 → `count`=3; then `outReady`=1 → 8'h35, 8'hA5, 8'h00 on consecutive cycles, `empty`=1 after.
- DEPTH=16: push 17 bytes 8'h00..8'h10, no pops → `full`=1, `overflow`=1, byte 8'h10 lost; drain yields 8'h00..8'h0F; `clearOverflow` → `overflow`=0.
- Full FIFO, simultaneous push 8'h5A and pop → `count` stays 16, `overflow` stays 0, 8'h5A emerges last.
- `rxDone` with `rxErr`=1, byte 8'hFF: without macro → `count` unchanged, `errCount`=1; with macro → stored, `outErr`=1 with `outData`=8'hFF.
- Wrap: 40 push/pop pairs of incrementing bytes with random `outReady` → output sequence identical to input; assert reset mid-stream → `count`=0, `outValid`=0 immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants. The entry width depends on UART_RX_FIFO_ERR_TAG_EN:
// a tagged entry holds the framing-error bit above the data byte.
package uart_pkg;

  localparam int UART_BYTE_W                = 8;
  localparam int UART_RX_FIFO_DEPTH_DEFAULT = 16;
  localparam int UART_ERRCNT_W              = 8;

`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam int UART_RX_ENTRY_W = UART_BYTE_W + 1;
`else
  localparam int UART_RX_ENTRY_W = UART_BYTE_W;
`endif

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x W storage for the receive FIFO. It has one synchronous write port
// and one asynchronous read port. The contents are never reset.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the Uart8 receiver, with level/flag/overflow/error accounting.
// Define UART_RX_FIFO_ERR_TAG_EN to store errored bytes with a tag and expose outErr.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH_DEFAULT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rxDone,
  input  logic                     rxErr,
  input  logic [UART_BYTE_W-1:0]   rxByte,
  output logic [UART_BYTE_W-1:0]   outData,
  output logic                     outValid,
  input  logic                     outReady,
`ifdef UART_RX_FIFO_ERR_TAG_EN
  output logic                     outErr,
`endif
  output logic [AW:0]              count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  input  logic                     clearOverflow,
  output logic [UART_ERRCNT_W-1:0] errCount
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [AW:0]                wp;
  logic [AW:0]                rp;
  logic [UART_RX_ENTRY_W-1:0] wr_entry;
  logic [UART_RX_ENTRY_W-1:0] rd_entry;
  logic                       push_req;
  logic                       pop;
  logic                       do_push;
  logic                       drop;

`ifdef UART_RX_FIFO_ERR_TAG_EN
  assign push_req = rxDone;
  assign wr_entry = {rxErr, rxByte};
  assign outErr   = outValid & rd_entry[UART_BYTE_W];
`else
  assign push_req = rxDone & ~rxErr;
  assign wr_entry = rxByte;
`endif

  // The extra pointer MSB separates full from empty once the index wraps.
  assign count    = wp - rp;
  assign full     = (count == FULL_LEVEL);
  assign empty    = (count == '0);
  assign outValid = ~empty;
  assign pop      = outValid & outReady;
  assign do_push  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;
  assign outData  = outValid ? rd_entry[UART_BYTE_W-1:0] : '0;

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (UART_RX_ENTRY_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (do_push),
    .wr_addr (wp[AW-1:0]),
    .wr_data (wr_entry),
    .rd_addr (rp[AW-1:0]),
    .rd_data (rd_entry)
  );

  // When overflow is set and cleared in the same cycle, the set takes priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
      errCount <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (pop)     rp <= rp + (AW+1)'(1);
      if (drop)               overflow <= 1'b1;
      else if (clearOverflow) overflow <= 1'b0;
      if (rxDone && rxErr && (errCount != '1)) errCount <= errCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table vectors, directed corner cases and
// random traffic compared against a queue-based model; honours UART_RX_FIFO_ERR_TAG_EN.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rxDone = 1'b0;
  logic        rxErr = 1'b0;
  logic [7:0]  rxByte = 8'h00;
  logic [7:0]  outData;
  logic        outValid;
  logic        outReady = 1'b0;
  logic        outErr_w;
  logic [AW:0] count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        clearOverflow = 1'b0;
  logic [7:0]  errCount;

  int checks = 0;
  int passes = 0;

  logic [8:0] mq[$];
  logic [7:0] popped[$];
  bit         m_ov;
  int         m_err;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .rxDone        (rxDone),
    .rxErr         (rxErr),
    .rxByte        (rxByte),
    .outData       (outData),
    .outValid      (outValid),
    .outReady      (outReady),
`ifdef UART_RX_FIFO_ERR_TAG_EN
    .outErr        (outErr_w),
`endif
    .count         (count),
    .full          (full),
    .empty         (empty),
    .overflow      (overflow),
    .clearOverflow (clearOverflow),
    .errCount      (errCount)
  );

`ifndef UART_RX_FIFO_ERR_TAG_EN
  assign outErr_w = 1'b0;
`endif

  typedef struct {
    logic       d;
    logic       e;
    logic [7:0] b;
    logic       r;
    logic       c;
    int         exp_count;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ov;
    int         exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic checkOutput(input string tag);
    logic [8:0] head;
    head = (mq.size() > 0) ? mq[0] : 9'h000;
    checkVal({tag, " count"}, 32'(count), 32'(mq.size()));
    checkVal({tag, " outValid"}, 32'(outValid), 32'(mq.size() > 0));
    checkVal({tag, " outData"}, 32'(outData), 32'(head[7:0]));
    checkVal({tag, " full"}, 32'(full), 32'(mq.size() == DEPTH));
    checkVal({tag, " empty"}, 32'(empty), 32'(mq.size() == 0));
    checkVal({tag, " overflow"}, 32'(overflow), 32'(m_ov));
    checkVal({tag, " errCount"}, 32'(errCount), 32'(m_err));
    if (TAG) checkVal({tag, " outErr"}, 32'(outErr_w), 32'(head[8]));
  endtask

  // Model step: decide pop/push/drop from pre-edge occupancy, then clock and compare.
  task automatic applyStimulus(input logic d, input logic e, input logic [7:0] b,
                               input logic r, input logic c, input string tag);
    int  sz;
    bit  pop_m;
    bit  push_m;
    bit  ovset;
    rxDone = d; rxErr = e; rxByte = b; outReady = r; clearOverflow = c;
    sz     = mq.size();
    pop_m  = (sz > 0) && r;
    push_m = d && (TAG || !e);
    ovset  = 1'b0;
    if (pop_m) begin
      popped.push_back(outData);
      void'(mq.pop_front());
    end
    if (push_m) begin
      if (sz < DEPTH || pop_m) mq.push_back({e, b});
      else ovset = 1'b1;
    end
    if (ovset) m_ov = 1'b1;
    else if (c) m_ov = 1'b0;
    if (d && e && m_err < 255) m_err++;
    @(posedge clk);
    #1;
    rxDone = 1'b0; rxErr = 1'b0; outReady = 1'b0; clearOverflow = 1'b0;
    checkOutput(tag);
  endtask

  task automatic doReset(input string tag);
    reset = 1'b0;
    #2;
    checkVal({tag, " rst count"}, 32'(count), 32'd0);
    checkVal({tag, " rst outValid"}, 32'(outValid), 32'd0);
    checkVal({tag, " rst outData"}, 32'(outData), 32'd0);
    checkVal({tag, " rst empty"}, 32'(empty), 32'd1);
    checkVal({tag, " rst full"}, 32'(full), 32'd0);
    checkVal({tag, " rst overflow"}, 32'(overflow), 32'd0);
    checkVal({tag, " rst errCount"}, 32'(errCount), 32'd0);
    if (TAG) checkVal({tag, " rst outErr"}, 32'(outErr_w), 32'd0);
    mq.delete();
    m_ov  = 1'b0;
    m_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int sent;
    int cyc;

    vecs[0] = '{1'b1, 1'b0, 8'h35, 1'b0, 1'b0, 1, 1'b1, 8'h35, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 2, 1'b1, 8'h35, 1'b0, 0};
    vecs[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3, 1'b1, 8'h35, 1'b0, 0};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'hA5, 1'b0, 0};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h00, 1'b0, 0};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 0};
    if (TAG) begin
      vecs[6] = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1, 1'b1, 8'hFF, 1'b0, 1};
      vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1};
    end else begin
      vecs[6] = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1};
      vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1};
    end

    doReset("init");

    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "idle");

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].d, vecs[i].e, vecs[i].b, vecs[i].r, vecs[i].c, "vec");
      checkVal($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
      checkVal($sformatf("vec%0d outValid", i), 32'(outValid), 32'(vecs[i].exp_valid));
      checkVal($sformatf("vec%0d outData", i), 32'(outData), 32'(vecs[i].exp_data));
      checkVal($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].exp_ov));
      checkVal($sformatf("vec%0d errCount", i), 32'(errCount), 32'(vecs[i].exp_err));
    end

    // Overfill by one, drain, then clear the sticky flag.
    doReset("ovf");
    for (int i = 0; i <= DEPTH; i++) applyStimulus(1'b1, 1'b0, 8'(i), 1'b0, 1'b0, "fill");
    checkVal("ovf full", 32'(full), 32'd1);
    checkVal("ovf overflow", 32'(overflow), 32'd1);
    popped.delete();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "drain");
    checkVal("ovf drained", 32'(popped.size()), 32'(DEPTH));
    for (int i = 0; i < popped.size(); i++) checkVal("ovf order", 32'(popped[i]), 32'(i));
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "clrov");
    checkVal("clr overflow", 32'(overflow), 32'd0);

    // Simultaneous push and pop while full.
    doReset("fullpp");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 8'(8'h20 + i), 1'b0, 1'b0, "fill2");
    applyStimulus(1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, "pushpop");
    checkVal("pushpop count", 32'(count), 32'(DEPTH));
    checkVal("pushpop overflow", 32'(overflow), 32'd0);
    popped.delete();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "drain2");
    checkVal("pushpop drained", 32'(popped.size()), 32'(DEPTH));
    if (popped.size() > 0) checkVal("pushpop last", 32'(popped[$]), 32'h5A);

    // Wrap the pointers with random backpressure; order must be preserved.
    doReset("wrap");
    popped.delete();
    sent = 0;
    cyc  = 0;
    while (popped.size() < 40 && cyc < 600) begin
      logic d;
      d = (sent < 40) && (mq.size() < DEPTH) && ($urandom_range(0, 1) == 1);
      applyStimulus(d, 1'b0, 8'(sent), 1'($urandom_range(0, 1)), 1'b0, "wrap");
      if (d) sent++;
      cyc++;
    end
    checkVal("wrap popped", 32'(popped.size()), 32'd40);
    for (int i = 0; i < popped.size(); i++) checkVal("wrap order", 32'(popped[i]), 32'(i));

    // Reset asserted in the middle of traffic.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(8'h70 + i), 1'b0, 1'b0, "pre");
    doReset("mid");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "postrst");

    // Random traffic including errors, clears and overflow.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
                    8'($urandom), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 15) == 0), "rand");
    end

    // Drive errCount to saturation.
    doReset("sat");
    for (int i = 0; i < 258; i++) applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, "sat");
    checkVal("sat errCount", 32'(errCount), 32'd255);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
